uart_rx_fifo: RTL and testbench

- Receive-side byte buffer between the UART receiver and the Wishbone slave data path.
- Captures each received character, plus its parity-error flag, on the receiver's one-cycle valid pulse.
- Holds up to DEPTH entries so the bus master can read them at its own pace.
- Reports occupancy and sticky overrun status to the bus wrapper.

---
 rtl/uart_rx_fifo.sv | 144 ++++++++++++++
 tb/tb_uart_rx_fifo.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
//
// Receive-side byte buffer that sits between the UART receiver and the
// Wishbone slave data path. Every character is captured together with its
// parity-error flag on the receiver's one-cycle valid strobe. Up to DEPTH
// entries are held so the bus master can read them at its own pace.
// Occupancy and a sticky overrun flag are reported to the bus wrapper.
//
// Optional feature: define UART_RX_FIFO_TIMEOUT_EN to build an idle
// counter. That counter drives timeout_o when data has sat unread for
// TIMEOUT_CYCLES cycles. Without the macro, timeout_o is tied to 0.
//
// Ports:
//   clk_i            system clock
//   rst_i            synchronous reset, active-high
//   rx_data_i        character from the receiver
//   rx_data_vld_i    single-cycle push strobe
//   rx_parity_err_i  parity error of rx_data_i, sampled with the strobe
//   rd_en_i          pop request from the bus side
//   rd_data_o        popped character (holds until the next pop)
//   rd_perr_o        parity-error flag of the popped character
//   rd_vld_o         one-cycle pulse, rd_data_o/rd_perr_o valid
//   count_o          current occupancy
//   empty_o          count_o == 0
//   full_o           count_o == DEPTH
//   afull_o          count_o >= AFULL_LVL
//   overrun_o        sticky, a character was dropped
//   ovr_clr_i        clears overrun_o
//   timeout_o        idle timeout flag
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int DATA_BITS      = 8,
    parameter int DEPTH          = 16,
    parameter int AFULL_LVL      = 12,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [DATA_BITS-1:0]         rx_data_i,
    input  logic                         rx_data_vld_i,
    input  logic                         rx_parity_err_i,
    input  logic                         rd_en_i,
    output logic [DATA_BITS-1:0]         rd_data_o,
    output logic                         rd_perr_o,
    output logic                         rd_vld_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         empty_o,
    output logic                         full_o,
    output logic                         afull_o,
    output logic                         overrun_o,
    input  logic                         ovr_clr_i,
    output logic                         timeout_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_CNT = CW'(AFULL_LVL);

    logic [DATA_BITS:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic               push_ok;
    logic               pop_ok;

    assign empty_o = (count_o == '0);
    assign full_o  = (count_o == FULL_CNT);
    assign afull_o = (count_o >= AFULL_CNT);

    // A full FIFO still takes a push when a pop frees a slot in the same cycle.
    // An empty FIFO ignores the pop, even if a push arrives alongside it.
    assign pop_ok  = rd_en_i && !empty_o;
    assign push_ok = rx_data_vld_i && (!full_o || pop_ok);

    // Storage is not reset. Stale contents are unreachable once the pointers
    // and count are cleared.
    always_ff @(posedge clk_i) begin
        if (!rst_i && push_ok) begin
            mem[wr_ptr] <= {rx_parity_err_i, rx_data_i};
        end
    end

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_o <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop_ok)      count_o <= count_o + 1'b1;
            else if (pop_ok && !push_ok) count_o <= count_o - 1'b1;
        end
    end

    // Read register: the data holds between pops, and the valid signal is a single pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_data_o <= '0;
            rd_perr_o <= 1'b0;
            rd_vld_o  <= 1'b0;
        end else begin
            rd_vld_o <= pop_ok;
            if (pop_ok) begin
                {rd_perr_o, rd_data_o} <= mem[rd_ptr];
            end
        end
    end

    // Sticky overrun. When a dropped character and a clear arrive together, set wins.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            overrun_o <= 1'b0;
        end else if (rx_data_vld_i && !push_ok) begin
            overrun_o <= 1'b1;
        end else if (ovr_clr_i) begin
            overrun_o <= 1'b0;
        end
    end

`ifdef UART_RX_FIFO_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES+1);
    localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES);

    logic [TW-1:0] idle_cnt;

    // Counts cycles without traffic while data is waiting. The count saturates so
    // the flag stays up until the next push or pop.
    always_ff @(posedge clk_i) begin
        if (rst_i || push_ok || pop_ok || empty_o) begin
            idle_cnt <= '0;
        end else if (idle_cnt != TO_MAX) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    assign timeout_o = (idle_cnt == TO_MAX) && !empty_o;
`else
    assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_fifo
//
// Directed bench for uart_rx_fifo. A queue-based reference model tracks
// expected outputs. A negedge compare process checks every output on every
// cycle. Hand-computed literal checks pin the model at key points.
// Define UART_RX_FIFO_TIMEOUT_EN to also exercise the idle timeout.
// ---------------------------------------------------------------------------
module tb_uart_rx_fifo;

    localparam int DEPTH   = 16;
    localparam int AFULL   = 12;
    localparam int TIMEOUT = 8;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic [7:0] rx_data_i = '0;
    logic       rx_data_vld_i = 1'b0;
    logic       rx_parity_err_i = 1'b0;
    logic       rd_en_i = 1'b0;
    logic       ovr_clr_i = 1'b0;
    logic [7:0] rd_data_o;
    logic       rd_perr_o;
    logic       rd_vld_o;
    logic [4:0] count_o;
    logic       empty_o;
    logic       full_o;
    logic       afull_o;
    logic       overrun_o;
    logic       timeout_o;

    int tests  = 0;
    int failed = 0;
    bit check_en = 1'b0;

    uart_rx_fifo #(
        .DATA_BITS(8), .DEPTH(DEPTH), .AFULL_LVL(AFULL), .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .rx_data_i(rx_data_i), .rx_data_vld_i(rx_data_vld_i),
        .rx_parity_err_i(rx_parity_err_i), .rd_en_i(rd_en_i),
        .rd_data_o(rd_data_o), .rd_perr_o(rd_perr_o), .rd_vld_o(rd_vld_o),
        .count_o(count_o), .empty_o(empty_o), .full_o(full_o), .afull_o(afull_o),
        .overrun_o(overrun_o), .ovr_clr_i(ovr_clr_i), .timeout_o(timeout_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: a queue of {perr, data} entries plus expected registers.
    logic [8:0] q [$];
    logic [7:0] exp_data = '0;
    logic       exp_perr = 1'b0;
    logic       exp_vld  = 1'b0;
    logic       exp_ovr  = 1'b0;
    int         quiet    = 0;

    always @(posedge clk_i) begin
        bit was_empty, pop, push;
        if (rst_i) begin
            q.delete();
            exp_data = '0;
            exp_perr = 1'b0;
            exp_vld  = 1'b0;
            exp_ovr  = 1'b0;
            quiet    = 0;
        end else begin
            was_empty = (q.size() == 0);
            pop  = rd_en_i && !was_empty;
            push = rx_data_vld_i && (q.size() < DEPTH || pop);
            exp_vld = pop;
            if (pop) {exp_perr, exp_data} = q.pop_front();
            if (push) q.push_back({rx_parity_err_i, rx_data_i});
            if (rx_data_vld_i && !push) exp_ovr = 1'b1;
            else if (ovr_clr_i)         exp_ovr = 1'b0;
            if (push || pop || was_empty) quiet = 0;
            else if (quiet < TIMEOUT)     quiet = quiet + 1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Continuous compare against the model, away from the active edge.
    always @(negedge clk_i) begin
        logic exp_to;
        if (check_en) begin
`ifdef UART_RX_FIFO_TIMEOUT_EN
            exp_to = (quiet == TIMEOUT) && (q.size() != 0);
`else
            exp_to = 1'b0;
`endif
            checkOutput("count",   32'(count_o),   32'(q.size()));
            checkOutput("empty",   32'(empty_o),   32'(q.size() == 0));
            checkOutput("full",    32'(full_o),    32'(q.size() == DEPTH));
            checkOutput("afull",   32'(afull_o),   32'(q.size() >= AFULL));
            checkOutput("overrun", 32'(overrun_o), 32'(exp_ovr));
            checkOutput("rd_vld",  32'(rd_vld_o),  32'(exp_vld));
            checkOutput("rd_data", 32'(rd_data_o), 32'(exp_data));
            checkOutput("rd_perr", 32'(rd_perr_o), 32'(exp_perr));
            checkOutput("timeout", 32'(timeout_o), 32'(exp_to));
        end
    end

    // Drive one cycle of inputs. The task returns 1 time unit after the edge.
    task automatic applyStimulus(input logic vld, input logic [7:0] d, input logic pe,
                                 input logic rd, input logic clr, input logic rs);
        rx_data_vld_i   = vld;
        rx_data_i       = d;
        rx_parity_err_i = pe;
        rd_en_i         = rd;
        ovr_clr_i       = clr;
        rst_i           = rs;
        @(posedge clk_i);
        #1;
        rx_data_vld_i   = 1'b0;
        rx_data_i       = '0;
        rx_parity_err_i = 1'b0;
        rd_en_i         = 1'b0;
        ovr_clr_i       = 1'b0;
        rst_i           = 1'b0;
    endtask

    initial begin
        applyStimulus(0, 8'h00, 0, 0, 0, 1);
        applyStimulus(0, 8'h00, 0, 0, 0, 1);
        check_en = 1'b1;
        checkOutput("reset_count", 32'(count_o), 0);
        checkOutput("reset_empty", 32'(empty_o), 1);
        checkOutput("reset_data",  32'(rd_data_o), 0);

        // Three characters with parity flags 0, 1 and 0, followed by three back-to-back pops.
        applyStimulus(1, 8'h41, 0, 0, 0, 0);
        applyStimulus(1, 8'h42, 1, 0, 0, 0);
        applyStimulus(1, 8'h43, 0, 0, 0, 0);
        checkOutput("lit_count3", 32'(count_o), 3);
        applyStimulus(0, 8'h00, 0, 1, 0, 0);
        checkOutput("lit_pop1", 32'({rd_vld_o, rd_perr_o, rd_data_o}), 32'h241);
        applyStimulus(0, 8'h00, 0, 1, 0, 0);
        checkOutput("lit_pop2", 32'({rd_vld_o, rd_perr_o, rd_data_o}), 32'h342);
        applyStimulus(0, 8'h00, 0, 1, 0, 0);
        checkOutput("lit_pop3", 32'({rd_vld_o, rd_perr_o, rd_data_o}), 32'h243);
        checkOutput("lit_empty", 32'({count_o, empty_o}), 32'h01);
        applyStimulus(0, 8'h00, 0, 1, 0, 0);
        checkOutput("lit_pop_empty", 32'(rd_vld_o), 0);

        // Fill the FIFO, then overrun it, drain it in order and clear the overrun flag.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1, 8'(i), 0, 0, 0, 0);
            if (i == 10) checkOutput("lit_afull11", 32'(afull_o), 0);
            if (i == 11) checkOutput("lit_afull12", 32'(afull_o), 1);
        end
        checkOutput("lit_full", 32'(full_o), 1);
        applyStimulus(1, 8'hFF, 0, 0, 0, 0);
        checkOutput("lit_ovr", 32'({overrun_o, count_o}), 32'h30);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(0, 8'h00, 0, 1, 0, 0);
            checkOutput("lit_drain", 32'(rd_data_o), 32'(i));
        end
        checkOutput("lit_ovr_sticky", 32'(overrun_o), 1);
        applyStimulus(0, 8'h00, 0, 0, 1, 0);
        checkOutput("lit_ovr_clr", 32'(overrun_o), 0);

        // Push and pop in the same cycle while full.
        for (int i = 0; i < 16; i++) applyStimulus(1, 8'(i), 0, 0, 0, 0);
        applyStimulus(1, 8'hAA, 1, 1, 0, 0);
        checkOutput("lit_fullboth", 32'({overrun_o, count_o, rd_data_o}), 32'h1000);
        for (int i = 1; i < 16; i++) applyStimulus(0, 8'h00, 0, 1, 0, 0);
        checkOutput("lit_drain_0f", 32'(rd_data_o), 32'h0F);
        applyStimulus(0, 8'h00, 0, 1, 0, 0);
        checkOutput("lit_drain_aa", 32'({rd_perr_o, rd_data_o}), 32'h1AA);

        // Push and pop in the same cycle while empty: only the push takes effect.
        applyStimulus(1, 8'h55, 0, 1, 0, 0);
        checkOutput("lit_emptyboth", 32'({rd_vld_o, count_o}), 32'h01);
        applyStimulus(0, 8'h00, 0, 1, 0, 0);
        checkOutput("lit_pop55", 32'({rd_vld_o, rd_data_o}), 32'h155);

        // Reset in the middle of operation, with an overrun and a pending pop.
        for (int i = 0; i < 5; i++) applyStimulus(1, 8'(8'h60 + i), 1, 0, 0, 0);
        for (int i = 0; i < 12; i++) applyStimulus(1, 8'h77, 0, 0, 0, 0);
        applyStimulus(0, 8'h00, 0, 1, 0, 1);
        checkOutput("lit_rst_state", 32'({overrun_o, rd_vld_o, count_o, empty_o, rd_data_o}), 32'h100);
        applyStimulus(0, 8'h00, 0, 0, 0, 0);
        checkOutput("lit_rst_novld", 32'(rd_vld_o), 0);

`ifdef UART_RX_FIFO_TIMEOUT_EN
        // The idle timeout fires after TIMEOUT quiet cycles with data pending.
        applyStimulus(1, 8'h33, 0, 0, 0, 0);
        for (int i = 0; i < TIMEOUT - 1; i++) applyStimulus(0, 8'h00, 0, 0, 0, 0);
        checkOutput("lit_to_before", 32'(timeout_o), 0);
        applyStimulus(0, 8'h00, 0, 0, 0, 0);
        checkOutput("lit_to_fire", 32'(timeout_o), 1);
        applyStimulus(0, 8'h00, 0, 0, 0, 0);
        checkOutput("lit_to_hold", 32'(timeout_o), 1);
        applyStimulus(0, 8'h00, 0, 1, 0, 0);
        checkOutput("lit_to_drop", 32'(timeout_o), 0);
        for (int i = 0; i < TIMEOUT + 2; i++) applyStimulus(0, 8'h00, 0, 0, 0, 0);
        checkOutput("lit_to_empty", 32'(timeout_o), 0);
`endif

        applyStimulus(0, 8'h00, 0, 0, 0, 0);
        @(negedge clk_i);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
